// File: rtl/mux_arbiter_pkg.sv
// Shared types and sizing for the four-requester round-robin mux arbiter.
package mux_arbiter_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request bit scanning from ptr upward, mod N_REQ.
module rr_pick
    import mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        idx   = ptr;
        any   = |req;
        found = 1'b0;
        cand  = '0;
        // Index arithmetic is SEL_W wide, so the wrap past N_REQ-1 is free.
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving a shared DW-bit output through an index-driven 4:1 mux.
//   state | meaning
//   IDLE  | no grant held; arbitrate among live requests from ptr
//   GRANT | requester S owns the output until accepted or withdrawn
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [SEL_W-1:0]    S,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    ack
);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel, sel_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             in_grant;
    logic             xfer;
    logic [N_REQ-1:0] sel_oh;
    logic [DW-1:0]    words [N_REQ];
    logic [DW-1:0]    word_sel;

    rr_pick u_rr_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_nxt   = pick_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    ptr_nxt   = sel + SEL_W'(1);
                    state_nxt = IDLE;
                end else if (!req[sel]) begin
                    // Withdrawn grant: priority pointer stays put so the same requester keeps first claim.
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            words[k] = data_in[k*DW +: DW];
        end
    end

    assign word_sel  = words[sel];
    assign sel_oh    = N_REQ'(1) << sel;
    assign in_grant  = (state == GRANT);
    assign out_valid = in_grant && req[sel];
    assign xfer      = out_valid && out_ready;
    assign out_data  = out_valid ? word_sel : '0;
    assign grant     = in_grant ? sel_oh : '0;
    assign ack       = xfer ? sel_oh : '0;
    assign S         = sel;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: per-cycle vector table, reset corner cases, round-robin scoreboard.
module tb_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  S;
    logic [3:0]  grant;
    logic [3:0]  ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic        rdy;
        logic        ev;
        logic [1:0]  es;
        logic [3:0]  eg;
        logic [3:0]  ea;
        logic [7:0]  ed;
    } vec_t;

    vec_t tv[$];
    int   exp_q[$];

    mux_arbiter #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .S         (S),
        .grant     (grant),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [31:0] d, input logic rd,
                       input logic v, input logic [1:0] s, input logic [3:0] g,
                       input logic [3:0] a, input logic [7:0] od);
        vec_t t;
        t.req = r; t.din = d; t.rdy = rd;
        t.ev = v; t.es = s; t.eg = g; t.ea = a; t.ed = od;
        tv.push_back(t);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [1:0] s,
                           input logic [3:0] g, input logic [3:0] a, input logic [7:0] od);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".S"},     32'(S),         32'(s));
        chk({tag, ".grant"}, 32'(grant),     32'(g));
        chk({tag, ".ack"},   32'(ack),       32'(a));
        chk({tag, ".data"},  32'(out_data),  32'(od));
    endtask

    initial begin
        int last;
        int e;

        rst_n = 1'b0; req = '0; data_in = '0; out_ready = 1'b0;

        // Reset values, including with live requests and clock edges while held.
        #3;
        chk_all("rst0", 1'b0, 2'd0, 4'b0000, 4'b0000, 8'h00);
        req = 4'b1111; data_in = 32'h44332211; out_ready = 1'b1;
        #20;
        chk_all("rst_held", 1'b0, 2'd0, 4'b0000, 4'b0000, 8'h00);
        req = '0; data_in = '0; out_ready = 1'b0;
        #7 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request (word 2 = A5)
        add(4'b0100, 32'h00A50000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'h00);
        add(4'b0100, 32'h00A50000, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0100, 8'hA5);
        add(4'b0000, 32'h00000000, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 8'h00);
        // Backpressure on requester 1 while requester 3 rises
        add(4'b0010, 32'h00003C00, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 8'h00);
        for (int i = 0; i < 5; i++)
            add(4'b1010, 32'h77003C00, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 8'h3C);
        add(4'b1010, 32'h77003C00, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0010, 8'h3C);
        add(4'b1000, 32'h77003C00, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 8'h00);
        add(4'b1000, 32'h77003C00, 1'b1, 1'b1, 2'd3, 4'b1000, 4'b1000, 8'h77);
        add(4'b0000, 32'h00000000, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 8'h00);
        // Withdrawal by requester 0, then re-request wins again
        add(4'b0011, 32'h00002211, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 8'h00);
        add(4'b0011, 32'h00002211, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 8'h11);
        add(4'b0010, 32'h00002211, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 8'h00);
        add(4'b0011, 32'h00002211, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'h00);
        add(4'b0011, 32'h00002211, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001, 8'h11);
        add(4'b0000, 32'h00000000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'h00);

        foreach (tv[i]) begin
            req = tv[i].req; data_in = tv[i].din; out_ready = tv[i].rdy;
            #1;
            chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].es, tv[i].eg, tv[i].ea, tv[i].ed);
            @(posedge clk); #1;
        end

        // Async reset mid-grant (ptr is 1 here)
        req = 4'b0100; data_in = 32'h00A50000; out_ready = 1'b0;
        @(posedge clk); #1;
        chk_all("pre_rst_grant", 1'b1, 2'd2, 4'b0100, 4'b0000, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 4'b0000, 4'b0000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1; req = 4'b1000; data_in = 32'h77000000;
        #1;
        chk_all("post_rst_idle", 1'b0, 2'd0, 4'b0000, 4'b0000, 8'h00);
        @(posedge clk); #1;
        chk_all("post_rst_grant", 1'b1, 2'd3, 4'b1000, 4'b0000, 8'h77);
        out_ready = 1'b1;
        #1;
        chk("post_rst_ack", 32'(ack), 32'b1000);
        @(posedge clk); #1;

        // Round-robin fairness: all four requesting, ptr back at 0
        req = 4'b1111; data_in = 32'h44332211; out_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        last = -1;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            #1;
            if (ack !== 4'b0000) begin
                e = exp_q.pop_front();
                chk("rr_ack", 32'(ack), 32'(4'b0001 << e));
                chk("rr_data", 32'(out_data), 32'((e + 1) * 8'h11));
                if (last >= 0) chk("rr_gap", 32'(cyc - last), 32'd2);
                last = cyc;
            end
            @(posedge clk); #1;
        end
        chk("rr_pending", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: DW, default 8, width of each requester data word.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester request; bit i = requester i.
REQ-005 data_in  input  4*DW  requester data; requester i occupies bits [i*DW +: DW].
REQ-006 out_ready  input  1  downstream consumer accepts the word this cycle.
REQ-007 out_valid  output  1  shared output carries a valid word.
REQ-008 out_data  output  DW  shared output word, the selected requester's data.
REQ-009 S  output  2  mux select, the index of the current grantee.
REQ-010 grant  output  4  one-hot grant, or zero when no grant is held.
REQ-011 ack  output  4  one-hot, one-cycle pulse marking the cycle requester i's word is accepted.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT.
REQ-013 In IDLE with req != 0, the block SHALL pick the first set req bit scanning ptr, ptr+1, ... mod 4, load S with that index, and enter GRANT on the next edge.
- Arbitration latency: 1 cycle.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with S unchanged.
REQ-015 grant SHALL equal the one-hot decode of S while in GRANT, and 0 in IDLE.
REQ-016 out_valid SHALL equal (state==GRANT) AND req[S], combinationally.
REQ-017 out_data SHALL equal data_in word S when out_valid=1, and 0 otherwise.
- out_data is combinational from the live data_in.
REQ-018 A transfer SHALL occur in any cycle with out_valid=1 and out_ready=1; in that cycle ack[S]=1 and all other ack bits are 0.
REQ-019 On a transfer, the block SHALL set ptr to (S+1) mod 4 and return to IDLE.
- Peak throughput: 1 word per 2 cycles.
REQ-020 In GRANT with out_valid=1 and out_ready=0, the block SHALL hold state, S and grant.
- A grant is never pre-empted by another requester.
REQ-021 In GRANT with req[S]=0 (requester withdrew), the block SHALL return to IDLE with no ack and ptr unchanged.
REQ-022 A req bit rising while another requester holds a grant SHALL NOT alter S or grant before that grant ends.
REQ-023 ptr SHALL wrap from 3 to 0.
- With all four req bits held high, the grant order is 0,1,2,3,0,...
REQ-024 Requesters SHALL hold req and their data stable until their ack; the block does not register data_in.

Reset
REQ-025 While rst_n=0, the block SHALL be in IDLE with ptr=0, S=0, grant=0, ack=0, out_valid=0 and out_data=0, independent of clk.
REQ-026 Reset asserted mid-GRANT SHALL abort the grant immediately with no ack, and outputs SHALL take their reset values asynchronously.
REQ-027 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with req != 0.

Structure
REQ-028 Package mux_arbiter_pkg SHALL hold the state enum (IDLE, GRANT), N_REQ=4 and SEL_W=2.
REQ-029 Rotating-priority selection SHALL be a sub-module rr_pick with inputs req[3:0] and ptr[1:0], outputs idx[1:0] and any.
- rr_pick is purely combinational.
REQ-030 Data selection SHALL be an index-driven 4:1 DW-bit multiplexer inside mux_arbiter.

Verification
REQ-031 Single request: req=0100, data word 2 = 8'hA5, out_ready=1.
- Cycle 1: S=2, grant=0100, out_valid=1, out_data=A5, ack=0100.
- Cycle 2: IDLE, out_valid=0.
REQ-032 Round-robin fairness: req=1111 held, out_ready=1.
- Acks occur in order 0001, 0010, 0100, 1000, 0001.
- Acks land every other cycle.
REQ-033 Backpressure: grant held to requester 1 with out_ready=0 for 5 cycles while req[3] rises.
- S stays 1 and out_data stays stable throughout.
- After out_ready=1: ack=0010, then requester 3 is granted.
REQ-034 Withdrawal: requester 0 granted, req[0] drops before out_ready.
- Next cycle: IDLE, no ack, ptr=0.
- Requester 0 wins the next arbitration if it re-requests.
REQ-035 Async reset mid-grant: rst_n pulled low between edges while in GRANT.
- out_valid, grant and S go to 0 before the next edge.
- After release with req=1000, the grant goes to requester 3.
